// File: rtl/mips_controller.sv
// Multicycle main controller FSM for the 8-bit mini-MIPS datapath.
// Define MIPS_CTRL_ADDI_EN to add the ADDIEX/ADDIWR states for ADDI support.
module mips_controller #(
    parameter int unsigned OPW = 6,
    parameter int unsigned SW  = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    output logic           memread,
    output logic           memwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     aluop,
    output logic [3:0]     irwrite,
    output logic           iord,
    output logic           memtoreg,
    output logic           regdst,
    output logic           regwrite,
    output logic [1:0]     pcsource,
    output logic           pcen,
    output logic [SW-1:0]  state
);

    localparam logic [OPW-1:0] OpLb    = 6'b100000;
    localparam logic [OPW-1:0] OpSb    = 6'b101000;
    localparam logic [OPW-1:0] OpRtype = 6'b000000;
    localparam logic [OPW-1:0] OpBeq   = 6'b000100;
    localparam logic [OPW-1:0] OpJ     = 6'b000010;
`ifdef MIPS_CTRL_ADDI_EN
    localparam logic [OPW-1:0] OpAddi  = 6'b001000;
`endif

    // Encodings are implicit and consecutive from 0; ADDI states take 13 and 14.
    typedef enum logic [SW-1:0] {
        StFetch1,
        StFetch2,
        StFetch3,
        StFetch4,
        StDecode,
        StMemAdr,
        StLbRd,
        StLbWr,
        StSbWr,
        StRtypeEx,
        StRtypeWr,
        StBeqEx,
        StJEx
`ifdef MIPS_CTRL_ADDI_EN
        ,
        StAddiEx,
        StAddiWr
`endif
    } state_e;

    state_e state_q, state_d;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = StFetch1;
        memread  = 1'b0;
        memwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        irwrite  = 4'b0000;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        regwrite = 1'b0;
        pcsource = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        case (state_q)
            StFetch1: begin
                memread = 1'b1;
                irwrite = 4'b0001;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                state_d = StFetch2;
            end
            StFetch2: begin
                memread = 1'b1;
                irwrite = 4'b0010;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                state_d = StFetch3;
            end
            StFetch3: begin
                memread = 1'b1;
                irwrite = 4'b0100;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                state_d = StFetch4;
            end
            StFetch4: begin
                memread = 1'b1;
                irwrite = 4'b1000;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                alusrcb = 2'b11;
                case (op)
                    OpLb, OpSb: state_d = StMemAdr;
                    OpRtype:    state_d = StRtypeEx;
                    OpBeq:      state_d = StBeqEx;
                    OpJ:        state_d = StJEx;
`ifdef MIPS_CTRL_ADDI_EN
                    OpAddi:     state_d = StAddiEx;
`endif
                    default:    state_d = StFetch1;
                endcase
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OpLb) ? StLbRd : StSbWr;
            end
            StLbRd: begin
                memread = 1'b1;
                iord    = 1'b1;
                state_d = StLbWr;
            end
            StLbWr: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            StSbWr: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            StRtypeEx: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = StRtypeWr;
            end
            StRtypeWr: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            StBeqEx: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                branch   = 1'b1;
                pcsource = 2'b01;
            end
            StJEx: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
`ifdef MIPS_CTRL_ADDI_EN
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = StAddiWr;
            end
            StAddiWr: begin
                regwrite = 1'b1;
            end
`endif
            default: state_d = StFetch1;
        endcase
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

endmodule

// File: tb/tb_mips_controller.sv
// Randomized self-checking bench for mips_controller: per-opcode state paths
// and a per-state output table are checked every cycle.
module tb_mips_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
    logic [1:0] alusrcb, aluop, pcsource;
    logic [3:0] irwrite;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [3:0] irwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic [1:0] pcsource;
        logic       pcen;
    } outs_t;

    int path[$];

    mips_controller dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .zero     (zero),
        .memread  (memread),
        .memwrite (memwrite),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .aluop    (aluop),
        .irwrite  (irwrite),
        .iord     (iord),
        .memtoreg (memtoreg),
        .regdst   (regdst),
        .regwrite (regwrite),
        .pcsource (pcsource),
        .pcen     (pcen),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Whole-instruction state sequence, starting at FETCH1.
    function automatic void build_path(input logic [5:0] o);
        path = {0, 1, 2, 3, 4};
        case (o)
            6'b100000: path = {path, 5, 6, 7};
            6'b101000: path = {path, 5, 8};
            6'b000000: path = {path, 9, 10};
            6'b000100: path = {path, 11};
            6'b000010: path = {path, 12};
`ifdef MIPS_CTRL_ADDI_EN
            6'b001000: path = {path, 13, 14};
`endif
            default: ;
        endcase
    endfunction

    function automatic outs_t expected(input int st, input logic z);
        outs_t e = '0;
        if (st <= 3) begin
            e.memread = 1'b1;
            e.alusrcb = 2'b01;
            e.irwrite = 4'b0001 << st;
            e.pcen    = 1'b1;
        end
        case (st)
            4:  e.alusrcb = 2'b11;
            5:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            6:  begin e.memread = 1'b1; e.iord = 1'b1; end
            7:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            8:  begin e.memwrite = 1'b1; e.iord = 1'b1; end
            9:  begin e.alusrca = 1'b1; e.aluop = 2'b10; end
            10: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            11: begin e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsource = 2'b01; e.pcen = z; end
            12: begin e.pcsource = 2'b10; e.pcen = 1'b1; end
`ifdef MIPS_CTRL_ADDI_EN
            13: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            14: e.regwrite = 1'b1;
`endif
            default: ;
        endcase
        return e;
    endfunction

    function automatic outs_t observed();
        return '{memread, memwrite, alusrca, alusrcb, aluop, irwrite, iord, memtoreg,
                 regdst, regwrite, pcsource, pcen};
    endfunction

    task automatic check_step(input string tag, input int exp_st);
        outs_t o, e;
        checks++;
        assert (state === 4'(exp_st)) else begin
            errors++;
            $error("FAIL %s state observed %0d expected %0d", tag, state, exp_st);
        end
        o = observed();
        e = expected(exp_st, zero);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s outputs st=%0d observed %h expected %h", tag, exp_st, o, e);
        end
    endtask

    // zmode: 0/1 force zero, 2 random. stop_at >= 0 returns after checking that step.
    task automatic run_instr(input logic [5:0] o, input int zmode, input int stop_at);
        build_path(o);
        for (int i = 0; i < path.size(); i++) begin
            // op only matters in DECODE and MEMADR; scramble it elsewhere.
            op   = (path[i] == 4 || path[i] == 5) ? o : 6'($urandom);
            zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            check_step($sformatf("op%b_step%0d", o, i), path[i]);
            if (i == stop_at) return;
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] rop;

    initial begin
        reset = 1'b1;
        op    = 6'b000000;
        zero  = 1'b0;
        #2;
        check_step("reset_held_a", 0);
        #10;
        zero = 1'b1;
        #1;
        check_step("reset_held_b", 0);
        reset = 1'b0;

        // Async reset mid-RTYPEEX, no clock edge involved.
        run_instr(6'b000000, 2, 5);
        reset = 1'b1;
        #1;
        check_step("async_reset", 0);
        reset = 1'b0;

        run_instr(6'b100000, 2, -1);
        run_instr(6'b000100, 1, -1);
        run_instr(6'b000100, 0, -1);
        run_instr(6'b000000, 2, -1);
        run_instr(6'b111111, 2, -1);
        run_instr(6'b001000, 2, -1);
        run_instr(6'b101000, 2, -1);
        run_instr(6'b000010, 2, -1);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: rop = 6'b100000;
                1: rop = 6'b101000;
                2: rop = 6'b000000;
                3: rop = 6'b000100;
                4: rop = 6'b000010;
                5: rop = 6'b001000;
                default: rop = 6'($urandom);
            endcase
            run_instr(rop, 2, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
